vga_timing_gen: RTL and testbench

//  Raster timing generator for the VGA output path, one pixel per clk_in. Drives raster_x/raster_y,
//  the blanking flag "active" and hsync/vsync consumed by the text and bitmap mode stages.

---
 rtl/vga_timing_gen_pkg.sv | 30 +++
 rtl/vga_mod_counter.sv | 26 ++
 rtl/vga_timing_gen.sv | 90 +++++++++
 tb/tb_vga_timing_gen.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing defaults, mode_config bit masks and a window-compare helper.
// Imported by vga_mod_counter and vga_timing_gen.
package vga_timing_gen_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int POS_W = 10;

    // mode_config bit masks
    localparam logic [7:0] CFG_TEXT_40COL = 8'h01;
    localparam logic [7:0] CFG_TEXT_15ROW = 8'h02;
    localparam logic [7:0] CFG_BITMAP     = 8'h04;
    localparam logic [7:0] CFG_CURSOR_EN  = 8'h08;

    // True when lo <= v < lo+len
    function automatic logic in_window(input logic [POS_W-1:0] v, input int lo, input int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulus-N counter: sync reset to N-1, enable, combinational next value and wrap strobe.
// The next value is exported so the parent can register flags aligned with the counter.
module vga_mod_counter #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    always_comb begin
        wrap       = en && (count == W'(N - 1));
        count_next = count;
        if (en) count_next = wrap ? '0 : count + W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) count <= W'(N - 1);
        else           count <= count_next;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator, one pixel per clk_in, all outputs registered from next-counter values.
// Optional raster line IRQ enabled by defining VGA_LINE_IRQ_EN.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [7:0]       mode_config_in,
    input  logic [POS_W-1:0] irq_line_in,
    output logic [POS_W-1:0] raster_x,
    output logic [POS_W-1:0] raster_y,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       mode_config_out,
    output logic             line_irq
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    logic [POS_W-1:0] x_nxt, y_nxt;
    logic             x_wrap, unused_y_wrap;
    logic             frame_nxt;

    vga_mod_counter #(.N(H_TOTAL), .W(POS_W)) u_x_cnt (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .en         (1'b1),
        .count      (raster_x),
        .count_next (x_nxt),
        .wrap       (x_wrap)
    );

    vga_mod_counter #(.N(V_TOTAL), .W(POS_W)) u_y_cnt (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .en         (x_wrap),
        .count      (raster_y),
        .count_next (y_nxt),
        .wrap       (unused_y_wrap)
    );

    assign frame_nxt = (x_nxt == '0) && (y_nxt == '0);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            active          <= 1'b1;
            hsync           <= ~HSYNC_POL;
            vsync           <= ~VSYNC_POL;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
            mode_config_out <= 8'h00;
        end else begin
            active      <= !(in_window(x_nxt, 0, H_VISIBLE) && in_window(y_nxt, 0, V_VISIBLE));
            hsync       <= in_window(x_nxt, H_VISIBLE + H_FRONT, H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= in_window(y_nxt, V_VISIBLE + V_FRONT, V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= (x_nxt == '0);
            frame_start <= frame_nxt;
            // Mode only changes at frame boundaries so a frame never mixes two modes
            if (frame_nxt) mode_config_out <= mode_config_in;
        end
    end

`ifdef VGA_LINE_IRQ_EN
    // irq_line_in beyond the last line can never equal y_nxt, so it never fires
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) line_irq <= 1'b0;
        else           line_irq <= (int'(x_nxt) == H_VISIBLE) && (y_nxt == irq_line_in);
    end
`else
    logic unused_irq_line;
    assign unused_irq_line = ^irq_line_in;
    assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so whole frames fit in the run.
// Reference model tracks a linear pixel index within the frame and derives everything arithmetically.
module tb_vga_timing_gen;

    localparam int HV = 64, HF = 8, HS = 16, HB = 12;
    localparam int VV = 20, VF = 3, VS = 2,  VB = 5;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam bit HPOL = 1'b0, VPOL = 1'b0;
`ifdef VGA_LINE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mode_in;
    logic [9:0] irq_in;
    logic [9:0] raster_x, raster_y;
    logic       active, hsync, vsync, line_start, frame_start, line_irq;
    logic [7:0] mode_out;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .mode_config_in  (mode_in),
        .irq_line_in     (irq_in),
        .raster_x        (raster_x),
        .raster_y        (raster_y),
        .active          (active),
        .hsync           (hsync),
        .vsync           (vsync),
        .line_start      (line_start),
        .frame_start     (frame_start),
        .mode_config_out (mode_out),
        .line_irq        (line_irq)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         p = FT - 1;     // model pixel index within frame
    logic [7:0] e_mode = 8'h00;
    logic       e_irq = 1'b0;
    int         hs_cnt, irq_cnt, ls_cnt, fs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d (x=%0d y=%0d)", tag, obs, exp, p % HT, p / HT);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] m, input logic [9:0] irq);
        int ex, ey;
        rst_n = r; mode_in = m; irq_in = irq;
        @(posedge clk);
        if (!r) begin
            p = FT - 1; e_mode = 8'h00; e_irq = 1'b0;
        end else begin
            p = (p + 1) % FT;
            if (p == 0) e_mode = m;
            e_irq = IRQ_EN && (p % HT == HV) && (p / HT == int'(irq));
        end
        ex = p % HT; ey = p / HT;
        #1;
        chk("raster_x", 32'(raster_x), 32'(ex));
        chk("raster_y", 32'(raster_y), 32'(ey));
        chk("active", 32'(active), 32'(!(ex < HV && ey < VV)));
        chk("hsync", 32'(hsync), 32'((ex >= HV + HF && ex < HV + HF + HS) ? HPOL : !HPOL));
        chk("vsync", 32'(vsync), 32'((ey >= VV + VF && ey < VV + VF + VS) ? VPOL : !VPOL));
        chk("line_start", 32'(line_start), 32'(r && ex == 0));
        chk("frame_start", 32'(frame_start), 32'(r && p == 0));
        chk("mode_out", 32'(mode_out), 32'(e_mode));
        chk("line_irq", 32'(line_irq), 32'(e_irq));
        if (hsync == HPOL) hs_cnt++;
        if (line_irq) irq_cnt++;
        if (line_start) ls_cnt++;
        if (frame_start) fs_cnt++;
    endtask

    initial begin
        // reset state
        repeat (3) step(1'b0, 8'h5A, 10'd10);
        chk("rst_x", 32'(raster_x), 32'(HT - 1));
        chk("rst_y", 32'(raster_y), 32'(VT - 1));

        // release: first cycle (0,0) with both strobes, then strobes drop
        hs_cnt = 0; irq_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        step(1'b1, 8'h00, 10'd10);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_ls", 32'(line_start), 32'd1);
        for (int i = 1; i < FT; i++) step(1'b1, 8'h00, 10'd10);
        chk("frame_hsync_cnt", 32'(hs_cnt), 32'(HS * VT));
        chk("frame_line_cnt", 32'(ls_cnt), 32'(VT));
        chk("frame_fs_cnt", 32'(fs_cnt), 32'd1);
        chk("frame_irq_cnt", 32'(irq_cnt), 32'(IRQ_EN ? 1 : 0));

        // mode change mid-frame must wait for the next frame start
        for (int i = 0; i < 12 * HT + 31; i++) step(1'b1, 8'h00, 10'd10);
        for (int i = 0; i < FT && p != FT - 1; i++) step(1'b1, 8'h03, 10'd10);
        chk("mode_hold", 32'(mode_out), 32'h00);
        step(1'b1, 8'h03, 10'd10);
        chk("mode_load", 32'(mode_out), 32'h03);

        // reset mid-frame, then restart at (0,0)
        for (int i = 0; i < 12 * HT + 30; i++) step(1'b1, 8'h03, 10'd10);
        repeat (3) step(1'b0, 8'h03, 10'd10);
        chk("midrst_mode", 32'(mode_out), 32'h00);
        step(1'b1, 8'h07, 10'd10);
        chk("restart_fs", 32'(frame_start), 32'd1);
        chk("restart_mode", 32'(mode_out), 32'h07);

        // out-of-range irq line never fires
        irq_cnt = 0;
        for (int i = 1; i < FT; i++) step(1'b1, 8'h07, 10'd600);
        step(1'b1, 8'h07, 10'(VT));
        for (int i = 1; i < FT; i++) step(1'b1, 8'h07, 10'(VT));
        chk("irq_oob_cnt", 32'(irq_cnt), 32'd0);

        // randomized: random mode each cycle, occasional irq line change and reset pulse
        begin
            logic [9:0] irq_r = 10'd5;
            for (int i = 0; i < 6000; i++) begin
                if ($urandom_range(0, 699) == 0)
                    irq_r = ($urandom_range(0, 2) == 0) ? 10'd600 : 10'($urandom_range(0, VT + 1));
                step(($urandom_range(0, 399) != 0), 8'($urandom), irq_r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
